// File: rtl/jam_pkg.sv
// Shared state encoding, mode constants and width helpers for the
// parametrised exhaustive job-assignment solver.
package jam_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_EVAL,
        S_PIVOT,
        S_SUCC,
        S_SWAP,
        S_REVERSE,
        S_DONE
    } state_e;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Index width for worker/job numbers; never narrower than one bit.
    function automatic int aw_of(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

    // Total-cost width: N <= 2**AW terms of CW bits cannot overflow CW+AW bits.
    function automatic int sw_of(input int n, input int cw);
        return cw + aw_of(n);
    endfunction

endpackage

// File: rtl/jam_param_if.sv
// Start/busy handshake, cost-ROM lookup and result bus of the solver.
// The master side requests runs and serves the ROM; the slave is the solver.
interface jam_param_if
    import jam_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 7,
    parameter int MW = 16,
    parameter int AW = aw_of(N),
    parameter int SW = sw_of(N, CW)
);
    logic            start;
    logic            mode;
    logic            busy;
    logic [AW-1:0]   W;
    logic [AW-1:0]   J;
    logic [CW-1:0]   Cost;
    logic            Valid;
    logic [SW-1:0]   BestCost;
    logic [MW-1:0]   MatchCount;
    logic [N*AW-1:0] BestPerm;

    modport master (
        output start, mode, Cost,
        input  busy, W, J, Valid, BestCost, MatchCount, BestPerm
    );

    modport slave (
        input  start, mode, Cost,
        output busy, W, J, Valid, BestCost, MatchCount, BestPerm
    );
endinterface

// File: rtl/jam_perm_step.sv
// Permutation register array and the lexicographic next-permutation walk
// (pivot search, successor search, swap, suffix reversal).
module jam_perm_step
    import jam_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = aw_of(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            load,
    input  logic            step_req,
    output logic            step_done,
    output logic            last_perm,
    output logic [N*AW-1:0] perm
);

    state_e        st_q, st_d;
    logic [AW-1:0] perm_q [N];
    logic [AW-1:0] perm_d [N];
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] lo_q, lo_d;
    logic [AW-1:0] hi_q, hi_d;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign perm[g*AW +: AW] = perm_q[g];
    end

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        st_d      = st_q;
        perm_d    = perm_q;
        i_d       = i_q;
        j_d       = j_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        step_done = 1'b0;
        last_perm = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (load) begin
                    for (int k = 0; k < N; k++) perm_d[k] = AW'(k);
                end else if (step_req) begin
                    i_d  = AW'(N - 2);
                    st_d = S_PIVOT;
                end
            end
            S_PIVOT: begin
                if (perm_q[i_q] < perm_q[i_q + AW'(1)]) begin
                    j_d  = AW'(N - 1);
                    st_d = S_SUCC;
                end else if (i_q == '0) begin
                    // Fully descending: the sweep is complete.
                    step_done = 1'b1;
                    last_perm = 1'b1;
                    st_d      = S_IDLE;
                end else begin
                    i_d = i_q - AW'(1);
                end
            end
            S_SUCC: begin
                if (perm_q[j_q] > perm_q[i_q]) st_d = S_SWAP;
                else                           j_d  = j_q - AW'(1);
            end
            S_SWAP: begin
                perm_d[i_q] = perm_q[j_q];
                perm_d[j_q] = perm_q[i_q];
                lo_d        = i_q + AW'(1);
                hi_d        = AW'(N - 1);
                st_d        = S_REVERSE;
            end
            S_REVERSE: begin
                if (lo_q < hi_q) begin
                    perm_d[lo_q] = perm_q[hi_q];
                    perm_d[hi_q] = perm_q[lo_q];
                    lo_d         = lo_q + AW'(1);
                    hi_d         = hi_q - AW'(1);
                end else begin
                    step_done = 1'b1;
                    st_d      = S_IDLE;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    // NOTE: perm is a handful of flops rather than a RAM, so it is reset like any register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q <= S_IDLE;
            for (int k = 0; k < N; k++) perm_q[k] <= '0;
            i_q  <= '0;
            j_q  <= '0;
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            st_q   <= st_d;
            perm_q <= perm_d;
            i_q    <= i_d;
            j_q    <= j_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
        end
    end

endmodule

// File: rtl/jam_param.sv
// Exhaustive job-assignment solver: sums each permutation's cost from an
// external ROM and keeps the optimum, its multiplicity and its first witness.
module jam_param
    import jam_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 7,
    parameter int MW = 16,
    parameter int AW = aw_of(N),
    parameter int SW = sw_of(N, CW)
) (
    input logic        CLK,
    input logic        RST,
    jam_param_if.slave bus
);

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [AW-1:0]   k_q, k_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [SW-1:0]   best_q, best_d;
    logic [MW-1:0]   count_q, count_d;
    logic [N*AW-1:0] best_perm_q, best_perm_d;

    logic [N*AW-1:0] perm;
    logic            load, step_req, step_done, last_perm, better;
    logic [AW-1:0]   w_sel, j_sel;

    jam_perm_step #(.N(N), .AW(AW)) u_step (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .step_req  (step_req),
        .step_done (step_done),
        .last_perm (last_perm),
        .perm      (perm)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        k_d         = k_q;
        sum_d       = sum_q;
        best_d      = best_q;
        count_d     = count_q;
        best_perm_d = best_perm_q;
        load        = 1'b0;
        step_req    = 1'b0;
        better      = (mode_q == MODE_MAX) ? (sum_q > best_q) : (sum_q < best_q);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    mode_d  = bus.mode;
                    k_d     = '0;
                    sum_d   = '0;
                    count_d = '0;
                    best_d  = (bus.mode == MODE_MIN) ? '1 : '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                sum_d = sum_q + SW'(bus.Cost);
                if (k_q == AW'(N - 1)) begin
                    k_d     = '0;
                    state_d = S_EVAL;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_EVAL: begin
                if (better) begin
                    best_d      = sum_q;
                    count_d     = MW'(1);
                    best_perm_d = perm;
                end else if (sum_q == best_q) begin
                    count_d = count_q + MW'(1);
                end
                sum_d    = '0;
                step_req = 1'b1;
                state_d  = S_PIVOT;
            end
            // The stepper walks PIVOT..REVERSE on its own; park here until it reports.
            S_PIVOT: begin
                if (step_done) state_d = last_perm ? S_DONE : S_ACCUM;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel = (state_q == S_ACCUM) ? k_q : '0;
        j_sel = perm[AW-1:0];
        for (int k = 1; k < N; k++) begin
            if (w_sel == AW'(k)) j_sel = perm[k*AW +: AW];
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_MIN;
            k_q         <= '0;
            sum_q       <= '0;
            best_q      <= '0;
            count_q     <= '0;
            best_perm_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            sum_q       <= sum_d;
            best_q      <= best_d;
            count_q     <= count_d;
            best_perm_q <= best_perm_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.Valid      = (state_q == S_DONE);
    assign bus.W          = w_sel;
    assign bus.J          = j_sel;
    assign bus.BestCost   = best_q;
    assign bus.MatchCount = count_q;
    assign bus.BestPerm   = best_perm_q;

endmodule

// File: tb/tb_jam_param.sv
// Self-checking bench for jam_param: N=6, N=3 and N=4 instances share one
// clock and reset; expected results are queued at launch and popped on Valid.
module tb_jam_param;

    localparam int TIMEOUT = 30000;

    typedef struct {
        string       name;
        logic [31:0] cost;
        logic [31:0] count;
        logic [31:0] perm;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    logic start_v [3];
    logic mode_v  [3];
    int   rom6;
    int   eval3 = 0;

    jam_param_if #(.N(6), .CW(7), .MW(16)) if6 ();
    jam_param_if #(.N(3), .CW(7), .MW(16)) if3 ();
    jam_param_if #(.N(4), .CW(7), .MW(16)) if4 ();

    jam_param #(.N(6), .CW(7), .MW(16)) u6 (.CLK(CLK), .RST(RST), .bus(if6));
    jam_param #(.N(3), .CW(7), .MW(16)) u3 (.CLK(CLK), .RST(RST), .bus(if3));
    jam_param #(.N(4), .CW(7), .MW(16)) u4 (.CLK(CLK), .RST(RST), .bus(if4));

    assign if6.start = start_v[0];
    assign if3.start = start_v[1];
    assign if4.start = start_v[2];
    assign if6.mode  = mode_v[0];
    assign if3.mode  = mode_v[1];
    assign if4.mode  = mode_v[2];

    // Cost ROMs: N=6 selectable (flat 5 / diagonal-zero), N=3 W*3+J, N=4 anti-diagonal cheap.
    always_comb if6.Cost = (rom6 == 0) ? 7'd5 : ((if6.J == if6.W) ? 7'd0 : 7'd10);
    always_comb if3.Cost = 7'(int'(if3.W) * 3 + int'(if3.J));
    always_comb if4.Cost = (if4.J == (2'd3 - if4.W)) ? 7'd1 : 7'd9;

    // One cycle with W==N-1 while busy marks one evaluated permutation.
    always @(negedge CLK) begin
        if (if3.busy === 1'b1 && if3.W == 2'd2) eval3 <= eval3 + 1;
    end

    logic [31:0] v_bc [3], v_mc [3], v_bp [3], v_w [3], v_j [3];
    logic        v_valid [3], v_busy [3];

    always_comb begin
        v_bc[0] = 32'(if6.BestCost);   v_mc[0] = 32'(if6.MatchCount); v_bp[0] = 32'(if6.BestPerm);
        v_bc[1] = 32'(if3.BestCost);   v_mc[1] = 32'(if3.MatchCount); v_bp[1] = 32'(if3.BestPerm);
        v_bc[2] = 32'(if4.BestCost);   v_mc[2] = 32'(if4.MatchCount); v_bp[2] = 32'(if4.BestPerm);
        v_w[0]  = 32'(if6.W);          v_w[1]  = 32'(if3.W);          v_w[2]  = 32'(if4.W);
        v_j[0]  = 32'(if6.J);          v_j[1]  = 32'(if3.J);          v_j[2]  = 32'(if4.J);
        v_valid[0] = if6.Valid;        v_valid[1] = if3.Valid;        v_valid[2] = if4.Valid;
        v_busy[0]  = if6.busy;         v_busy[1]  = if3.busy;         v_busy[2]  = if4.busy;
    end

    function automatic logic [31:0] ident(input int n, input int aw);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r = r | (32'(k) << (k * aw));
        return r;
    endfunction

    function automatic logic [31:0] rev(input int n, input int aw);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r = r | (32'(n - 1 - k) << (k * aw));
        return r;
    endfunction

    function automatic exp_t mk(input string name, input int cost, input int count, input logic [31:0] perm);
        exp_t e;
        e.name  = name;
        e.cost  = 32'(cost);
        e.count = 32'(count);
        e.perm  = perm;
        return e;
    endfunction

    task automatic pulse_start(input int u, input logic m);
        @(negedge CLK);
        mode_v[u]  = m;
        start_v[u] = 1'b1;
        @(negedge CLK);
        start_v[u] = 1'b0;
    endtask

    task automatic launch(input int u, input logic m, input exp_t e);
        sb.push_back(e);
        pulse_start(u, m);
    endtask

    task automatic wait_result(input int u);
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        while (v_valid[u] !== 1'b1 && n < TIMEOUT) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        if (v_valid[u] !== 1'b1) begin
            failed++;
            $display("FAIL %s_valid: no Valid within %0d cycles", e.name, TIMEOUT);
        end else begin
            tests++;
            if (v_bc[u] !== e.cost) begin
                failed++;
                $display("FAIL %s_cost: got %0d expected %0d", e.name, v_bc[u], e.cost);
            end
            tests++;
            if (v_mc[u] !== e.count) begin
                failed++;
                $display("FAIL %s_count: got %0d expected %0d", e.name, v_mc[u], e.count);
            end
            tests++;
            if (v_bp[u] !== e.perm) begin
                failed++;
                $display("FAIL %s_perm: got %h expected %h", e.name, v_bp[u], e.perm);
            end
            tests++;
            if (v_busy[u] !== 1'b1) begin
                failed++;
                $display("FAIL %s_busy_at_done: got %b expected 1", e.name, v_busy[u]);
            end
            @(negedge CLK);
            tests++;
            if (v_valid[u] !== 1'b0 || v_busy[u] !== 1'b0) begin
                failed++;
                $display("FAIL %s_pulse: valid/busy after done got %b%b expected 00",
                         e.name, v_valid[u], v_busy[u]);
            end
        end
    endtask

    task automatic check_zero(input string tag, input int u);
        tests++;
        if (v_busy[u] !== 1'b0 || v_valid[u] !== 1'b0) begin
            failed++;
            $display("FAIL %s_flags unit%0d: busy/valid got %b%b expected 00", tag, u, v_busy[u], v_valid[u]);
        end
        tests++;
        if (v_bc[u] !== 32'd0 || v_mc[u] !== 32'd0) begin
            failed++;
            $display("FAIL %s_result unit%0d: cost/count got %0d/%0d expected 0/0", tag, u, v_bc[u], v_mc[u]);
        end
        tests++;
        if (v_bp[u] !== 32'd0 || v_w[u] !== 32'd0 || v_j[u] !== 32'd0) begin
            failed++;
            $display("FAIL %s_perm_idx unit%0d: perm/W/J got %h/%0d/%0d expected 0/0/0",
                     tag, u, v_bp[u], v_w[u], v_j[u]);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        for (int u = 0; u < 3; u++) check_zero("reset", u);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_max_n3();
        int base;
        base = eval3;
        launch(1, 1'b1, mk("n3_max", 12, 6, ident(3, 2)));
        wait_result(1);
        tests++;
        if (eval3 - base != 6) begin
            failed++;
            $display("FAIL n3_eval_cycles: got %0d expected 6", eval3 - base);
        end
    endtask

    task automatic test_back_to_back();
        launch(2, 1'b0, mk("n4_min", 4, 1, rev(4, 2)));
        wait_result(2);
        repeat (5) @(negedge CLK);
        tests++;
        if (v_bc[2] !== 32'd4 || v_mc[2] !== 32'd1 || v_bp[2] !== rev(4, 2)) begin
            failed++;
            $display("FAIL n4_hold: got %0d/%0d/%h expected 4/1/%h", v_bc[2], v_mc[2], v_bp[2], rev(4, 2));
        end
        launch(2, 1'b1, mk("n4_max", 36, 9, ident(4, 2)));
        wait_result(2);
    endtask

    task automatic test_ignore_start();
        rom6 = 1;
        launch(0, 1'b0, mk("n6_diag_min", 0, 1, ident(6, 3)));
        repeat (10) @(negedge CLK);
        tests++;
        if (v_busy[0] !== 1'b1) begin
            failed++;
            $display("FAIL n6_busy_mid_run: got %b expected 1", v_busy[0]);
        end
        pulse_start(0, 1'b1);
        mode_v[0] = 1'b0;
        wait_result(0);
    endtask

    task automatic test_abort();
        int seen;
        rom6 = 0;
        pulse_start(0, 1'b0);
        tests++;
        if (v_busy[0] !== 1'b1) begin
            failed++;
            $display("FAIL abort_busy_before: got %b expected 1", v_busy[0]);
        end
        @(posedge CLK);
        #1 RST = 1'b1;
        #3;
        check_zero("abort", 0);
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (v_valid[0] === 1'b1 || v_busy[0] === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            failed++;
            $display("FAIL abort_quiet: valid/busy seen %0d cycles expected 0", seen);
        end
        launch(0, 1'b0, mk("n6_const_min", 30, 720, ident(6, 3)));
        wait_result(0);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            start_v[u] = 1'b0;
            mode_v[u]  = 1'b0;
        end
        rom6 = 0;
        test_reset();
        test_max_n3();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
